// File: rtl/ext_ram_sched.sv
// ext_ram_sched: ping-pong external frame RAM scheduler.
// Posted writes via FIFO, 3-stage tagged read pipe, deferred bank swap.
module ext_ram_sched #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 32,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              end_of_one_frame,
  input  logic              wr_pop_hold,
  input  logic              ref_rd_req,
  input  logic [ADDR_W-1:0] ref_rd_addr,
  output logic              ref_rd_ack,
  output logic              ref_rd_valid,
  output logic [DATA_W-1:0] ref_rd_data,
  input  logic              dis_wr_req,
  input  logic [ADDR_W-1:0] dis_wr_addr,
  input  logic [DATA_W-1:0] dis_wr_data,
  output logic              dis_wr_ready,
  output logic              ext_frame_RAM0_cs_n,
  output logic              ext_frame_RAM0_wr,
  output logic [ADDR_W-1:0] ext_frame_RAM0_addr,
  output logic [DATA_W-1:0] ext_frame_RAM0_din,
  input  logic [DATA_W-1:0] ext_frame_RAM0_dout,
  output logic              ext_frame_RAM1_cs_n,
  output logic              ext_frame_RAM1_wr,
  output logic [ADDR_W-1:0] ext_frame_RAM1_addr,
  output logic [DATA_W-1:0] ext_frame_RAM1_din,
  input  logic [DATA_W-1:0] ext_frame_RAM1_dout,
  output logic              bank_sel,
  output logic              swap_pending
);

  localparam int PW = $clog2(WFIFO_DEPTH);
  localparam logic [PW:0] PONE = {{PW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    SWAP
  } state_e;

  state_e state_q, state_d;
  logic bank_sel_q, bank_sel_d;

  logic [ADDR_W-1:0] fa_q [WFIFO_DEPTH];
  logic [DATA_W-1:0] fd_q [WFIFO_DEPTH];
  logic [PW:0] wptr_q, wptr_d;
  logic [PW:0] rptr_q, rptr_d;
  logic fifo_empty, fifo_full;
  logic push, pop, run;

  logic              wr_act_q, wr_act_d;
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              rd1_act_q, rd1_act_d;
  logic              rd1_bank_q, rd1_bank_d;
  logic [ADDR_W-1:0] rd1_addr_q, rd1_addr_d;
  logic              rd2_act_q, rd2_act_d;
  logic              rd2_bank_q, rd2_bank_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic w0, w1, r0, r1;

  assign run        = (state_q == RUN);
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) &&
                      (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

  assign ref_rd_ack   = ref_rd_req && run;
  assign dis_wr_ready = !fifo_full && run;
  assign push         = dis_wr_req && dis_wr_ready;
  assign pop          = !fifo_empty && !wr_pop_hold;

  assign bank_sel     = bank_sel_q;
  assign swap_pending = !run;
  assign ref_rd_valid = rd_valid_q;
  assign ref_rd_data  = rd_data_q;

  always_comb begin
    state_d    = state_q;
    bank_sel_d = bank_sel_q;
    unique case (state_q)
      RUN: begin
        if (end_of_one_frame) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty && !wr_act_q &&
            !rd1_act_q && !rd2_act_q)
          state_d = SWAP;
      end
      SWAP: begin
        state_d    = RUN;
        bank_sel_d = !bank_sel_q;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    wptr_d    = push ? wptr_q + PONE : wptr_q;
    rptr_d    = pop ? rptr_q + PONE : rptr_q;
    wr_act_d  = pop;
    wr_bank_d = bank_sel_q;
    wr_addr_d = '0;
    wr_data_d = '0;
    if (pop) begin
      wr_addr_d = fa_q[rptr_q[PW-1:0]];
      wr_data_d = fd_q[rptr_q[PW-1:0]];
    end
  end

  // Each read carries its bank so a swap can never misroute data.
  always_comb begin
    rd1_act_d  = ref_rd_ack;
    rd1_bank_d = !bank_sel_q;
    rd1_addr_d = ref_rd_ack ? ref_rd_addr : '0;
    rd2_act_d  = rd1_act_q;
    rd2_bank_d = rd1_bank_q;
    rd_valid_d = rd2_act_q;
    rd_data_d  = rd_data_q;
    if (rd2_act_q)
      rd_data_d = rd2_bank_q ? ext_frame_RAM1_dout
                             : ext_frame_RAM0_dout;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fa_q[wptr_q[PW-1:0]] <= dis_wr_addr;
      fd_q[wptr_q[PW-1:0]] <= dis_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      bank_sel_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      wr_act_q   <= 1'b0;
      wr_bank_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd1_act_q  <= 1'b0;
      rd1_bank_q <= 1'b0;
      rd1_addr_q <= '0;
      rd2_act_q  <= 1'b0;
      rd2_bank_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bank_sel_q <= bank_sel_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      wr_act_q   <= wr_act_d;
      wr_bank_q  <= wr_bank_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd1_act_q  <= rd1_act_d;
      rd1_bank_q <= rd1_bank_d;
      rd1_addr_q <= rd1_addr_d;
      rd2_act_q  <= rd2_act_d;
      rd2_bank_q <= rd2_bank_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign w0 = wr_act_q && !wr_bank_q;
  assign w1 = wr_act_q && wr_bank_q;
  assign r0 = rd1_act_q && !rd1_bank_q;
  assign r1 = rd1_act_q && rd1_bank_q;

  assign ext_frame_RAM0_cs_n = !(w0 || r0);
  assign ext_frame_RAM0_wr   = w0;
  assign ext_frame_RAM0_addr = w0 ? wr_addr_q :
                               (r0 ? rd1_addr_q : '0);
  assign ext_frame_RAM0_din  = w0 ? wr_data_q : '0;

  assign ext_frame_RAM1_cs_n = !(w1 || r1);
  assign ext_frame_RAM1_wr   = w1;
  assign ext_frame_RAM1_addr = w1 ? wr_addr_q :
                               (r1 ? rd1_addr_q : '0);
  assign ext_frame_RAM1_din  = w1 ? wr_data_q : '0;

endmodule

// File: tb/tb_ext_ram_sched.sv
// tb_ext_ram_sched: vector table plus scoreboard bench
// for the ping-pong frame RAM scheduler.
module tb_ext_ram_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, eof, hold, rd_req, wr_req;
  logic [13:0] rd_addr, wr_addr;
  logic [31:0] wr_data, rd_data;
  logic        rd_ack, rd_valid, wr_ready;
  logic        ram0_cs_n, ram0_wr, ram1_cs_n, ram1_wr;
  logic [13:0] ram0_addr, ram1_addr;
  logic [31:0] ram0_din, ram1_din, ram0_dout, ram1_dout;
  logic        bank_sel, swap_pending;

  ext_ram_sched dut (
    .clk(clk), .reset(reset), .end_of_one_frame(eof),
    .wr_pop_hold(hold),
    .ref_rd_req(rd_req), .ref_rd_addr(rd_addr),
    .ref_rd_ack(rd_ack), .ref_rd_valid(rd_valid),
    .ref_rd_data(rd_data),
    .dis_wr_req(wr_req), .dis_wr_addr(wr_addr),
    .dis_wr_data(wr_data), .dis_wr_ready(wr_ready),
    .ext_frame_RAM0_cs_n(ram0_cs_n), .ext_frame_RAM0_wr(ram0_wr),
    .ext_frame_RAM0_addr(ram0_addr), .ext_frame_RAM0_din(ram0_din),
    .ext_frame_RAM0_dout(ram0_dout),
    .ext_frame_RAM1_cs_n(ram1_cs_n), .ext_frame_RAM1_wr(ram1_wr),
    .ext_frame_RAM1_addr(ram1_addr), .ext_frame_RAM1_din(ram1_din),
    .ext_frame_RAM1_dout(ram1_dout),
    .bank_sel(bank_sel), .swap_pending(swap_pending)
  );

  typedef struct packed {
    logic        b;
    logic [13:0] a;
    logic [31:0] d;
  } wexp_t;

  typedef struct {
    logic e, rd;
    logic [13:0] ra;
    logic wr;
    logic [13:0] wa;
    logic [31:0] wd;
    logic ack, rdy, sp, bs;
  } vec_t;

  int ntests = 0;
  int nfail  = 0;
  wexp_t wq[$];
  logic [31:0] rq[$];

  bit [31:0] mem0 [16384];
  bit [31:0] mem1 [16384];
  bit        wv0 [16384];
  bit        wv1 [16384];
  bit [31:0] sh [2][16384];
  bit        shv [2][16384];

  logic tb_bsel = 1'b0;
  logic hold_n = 1'b0;
  logic nopush = 1'b0;
  logic s_ack, s_rdy, s_sp, s_bs;

  function automatic logic [31:0] pat(input logic b, input logic [13:0] a);
    if (b && a == 14'h123) return 32'hDEADBEEF;
    return {(b ? 16'hB1B1 : 16'hB0B0), 2'b00, a};
  endfunction

  function automatic logic [31:0] exp_rd(input logic b, input logic [13:0] a);
    return shv[b][a] ? sh[b][a] : pat(b, a);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Synchronous RAM models: data appears the cycle after a read select.
  always @(posedge clk) begin
    if (!ram0_cs_n) begin
      if (ram0_wr) begin
        mem0[ram0_addr] <= ram0_din;
        wv0[ram0_addr]  <= 1'b1;
      end else
        ram0_dout <= wv0[ram0_addr] ? mem0[ram0_addr] : pat(1'b0, ram0_addr);
    end
    if (!ram1_cs_n) begin
      if (ram1_wr) begin
        mem1[ram1_addr] <= ram1_din;
        wv1[ram1_addr]  <= 1'b1;
      end else
        ram1_dout <= wv1[ram1_addr] ? mem1[ram1_addr] : pat(1'b1, ram1_addr);
    end
  end

  task automatic pop_wr(input logic b, input logic [13:0] a,
                        input logic [31:0] d);
    wexp_t e;
    if (wq.size() == 0) begin
      nfail++;
      $display("FAIL wr_unexpected: got bank%0d addr %0h", b, a);
    end else begin
      e = wq.pop_front();
      chk("wr_port", {17'b0, b, a, d}, {17'b0, e});
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (!ram0_cs_n && ram0_wr) pop_wr(1'b0, ram0_addr, ram0_din);
      if (!ram1_cs_n && ram1_wr) pop_wr(1'b1, ram1_addr, ram1_din);
      if (ram0_cs_n)
        chk("idle0", {ram0_wr, ram0_addr, ram0_din}, 64'd0);
      if (ram1_cs_n)
        chk("idle1", {ram1_wr, ram1_addr, ram1_din}, 64'd0);
      if (rd_valid) begin
        if (rq.size() == 0) begin
          nfail++;
          $display("FAIL rd_unexpected: got %0h", rd_data);
        end else
          chk("rd_data", rd_data, rq.pop_front());
      end
      if (eof && swap_pending) begin
        nfail++;
        $display("FAIL illegal_eof: pulse while swap pending");
      end
    end
  end

  task automatic cyc(input logic e, input logic rd, input logic [13:0] ra,
                     input logic wr, input logic [13:0] wa,
                     input logic [31:0] wd);
    wexp_t w;
    @(posedge clk);
    #1;
    eof = e; rd_req = rd; rd_addr = ra;
    wr_req = wr; wr_addr = wa; wr_data = wd;
    hold = hold_n;
    @(negedge clk);
    s_ack = rd_ack; s_rdy = wr_ready;
    s_sp = swap_pending; s_bs = bank_sel;
    if (!nopush) begin
      if (rd && rd_ack) rq.push_back(exp_rd(!tb_bsel, ra));
      if (wr && wr_ready) begin
        w = {tb_bsel, wa, wd};
        wq.push_back(w);
        sh[tb_bsel][wa]  = wd;
        shv[tb_bsel][wa] = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 14'h0, 1'b0, 14'h0, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t tv[18];
  int   na, nr;
  bit   done;

  initial begin
    reset = 1'b1; eof = 1'b0; hold = 1'b0;
    rd_req = 1'b0; rd_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;

    tv[0]  = '{1'b0, 1'b0, 14'h000, 1'b0, 14'h000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b1, 14'h040, 1'b0, 14'h000, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b0, 14'h000, 1'b1, 14'h050, 32'h11112222, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b0, 14'h000, 1'b0, 14'h000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b0, 14'h000, 1'b0, 14'h000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 1'b1, 14'h041, 1'b0, 14'h000, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 1'b1, 14'h042, 1'b1, 14'h051, 32'h33334444, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[7]  = '{1'b0, 1'b1, 14'h042, 1'b1, 14'h051, 32'h33334444, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[8]  = '{1'b0, 1'b1, 14'h042, 1'b1, 14'h051, 32'h33334444, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[9]  = '{1'b0, 1'b1, 14'h042, 1'b1, 14'h051, 32'h33334444, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[10] = '{1'b0, 1'b1, 14'h050, 1'b1, 14'h060, 32'h55556666, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[11] = '{1'b0, 1'b0, 14'h000, 1'b0, 14'h000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1};
    tv[12] = '{1'b0, 1'b0, 14'h000, 1'b0, 14'h000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1};
    tv[13] = '{1'b0, 1'b0, 14'h000, 1'b0, 14'h000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1};
    tv[14] = '{1'b1, 1'b0, 14'h000, 1'b0, 14'h000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1};
    tv[15] = '{1'b0, 1'b1, 14'h042, 1'b1, 14'h051, 32'h77778888, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[16] = '{1'b0, 1'b1, 14'h042, 1'b1, 14'h051, 32'h77778888, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[17] = '{1'b0, 1'b0, 14'h000, 1'b0, 14'h000, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_ports", {ram0_cs_n, ram1_cs_n, ram0_wr, ram1_wr,
        rd_valid, rd_data, bank_sel, swap_pending, wr_ready},
        {4'b1100, 1'b0, 32'h0, 3'b001});
    reset = 1'b0;

    // Handshake gating and idle/read-retire swap timing, cycle by cycle.
    for (int i = 0; i < 18; i++) begin
      tb_bsel = tv[i].bs;
      cyc(tv[i].e, tv[i].rd, tv[i].ra, tv[i].wr, tv[i].wa, tv[i].wd);
      chk($sformatf("vec%0d", i), {s_ack, s_rdy, s_sp, s_bs},
          {tv[i].ack, tv[i].rdy, tv[i].sp, tv[i].bs});
    end
    idle(4);
    tb_bsel = 1'b0;

    // Single read: port next cycle, data three cycles after ack.
    cyc(1'b0, 1'b1, 14'h123, 1'b0, 14'h0, 32'h0);
    chk("rd_ack", s_ack, 1);
    idle(1);
    chk("rd_port1", {ram1_cs_n, ram1_wr, ram1_addr}, {2'b00, 14'h123});
    chk("rd_port0_idle", ram0_cs_n, 1);
    idle(1);
    chk("rd_lat2", rd_valid, 0);
    idle(1);
    chk("rd_lat3", {rd_valid, rd_data}, {1'b1, 32'hDEADBEEF});
    idle(3);

    // Write burst: gapless bank0 writes starting two cycles after accept.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 14'h0, i < 6, 14'(16 + i), 32'hA000_0000 + i);
      if (i < 6) chk("burst_ready", s_rdy, 1);
      if (i >= 2)
        chk("burst_port", {ram0_cs_n, ram0_wr, ram0_addr},
            {2'b01, 14'(16 + i - 2)});
    end
    idle(3);

    // Stall on full via pop hold.
    hold_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 14'h0, 1'b1, 14'(32 + i), 32'hB000_0000 + i);
      chk("fill_ready", s_rdy, 1);
    end
    cyc(1'b0, 1'b0, 14'h0, 1'b1, 14'h024, 32'hB000_0004);
    chk("full_same_cycle", s_rdy, 0);
    hold_n = 1'b0;
    cyc(1'b0, 1'b0, 14'h0, 1'b1, 14'h024, 32'hB000_0004);
    chk("full_release_cycle", s_rdy, 0);
    cyc(1'b0, 1'b0, 14'h0, 1'b1, 14'h024, 32'hB000_0004);
    chk("full_after_pop", s_rdy, 1);
    idle(8);

    // Concurrent streams.
    na = 0; nr = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, 1'b1, 14'(512 + i), 1'b1, 14'(768 + i), $urandom);
      na += int'(s_ack);
      nr += int'(s_rdy);
    end
    chk("conc_acks", na, 100);
    chk("conc_readies", nr, 100);
    idle(6);

    // Swap with 3 queued writes and 2 reads in flight.
    hold_n = 1'b1;
    cyc(1'b0, 1'b0, 14'h0,   1'b1, 14'h030, 32'hC000_0000);
    cyc(1'b0, 1'b0, 14'h0,   1'b1, 14'h031, 32'hC000_0001);
    cyc(1'b0, 1'b1, 14'h210, 1'b1, 14'h032, 32'hC000_0002);
    cyc(1'b1, 1'b1, 14'h211, 1'b0, 14'h0,   32'h0);
    chk("eof_cycle_ack", s_ack, 1);
    hold_n = 1'b0;
    nopush = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      cyc(1'b0, 1'b1, 14'h300, 1'b0, 14'h0, 32'h0);
      if (s_sp) begin
        chk("swap_gate", {s_ack, s_rdy, s_bs}, 3'b000);
      end else begin
        done = 1'b1;
        chk("swap_bsel", s_bs, 1);
        chk("swap_wq_retired", wq.size(), 0);
        chk("swap_rq_retired", rq.size(), 0);
        chk("post_swap_ack", s_ack, 1);
        tb_bsel = 1'b1;
        if (s_ack) rq.push_back(exp_rd(1'b0, 14'h300));
      end
    end
    nopush = 1'b0;
    if (!done) begin
      nfail++;
      $display("FAIL swap_timeout: bank_sel %0d want 1", bank_sel);
    end
    idle(6);

    // Mid-burst asynchronous reset.
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b0, 14'h0, 1'b1, 14'(1024 + i), 32'hD000_0000 + i);
    @(posedge clk);
    #1;
    wr_req = 1'b0; rd_req = 1'b0;
    #2;
    chk("pre_reset_cs", ram1_cs_n, 0);
    reset = 1'b1;
    #1;
    chk("rst_cs_async", {ram0_cs_n, ram1_cs_n}, 2'b11);
    chk("rst_state", {bank_sel, swap_pending, rd_valid, wr_ready}, 4'b0001);
    wq.delete();
    rq.delete();
    tb_bsel = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, 14'h0, 1'b0, 14'h0, 32'h0);
      chk("post_rst_idle", {ram0_cs_n, ram1_cs_n, s_rdy, s_sp, s_bs},
          5'b11100);
    end

    chk("final_wq_empty", wq.size(), 0);
    chk("final_rq_empty", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
